// File: rtl/tdc_encoder.sv
// Per-pixel TDC back-end encoder.
// Stage 1 samples the thermometer words and coarse counters (and the monitor copies).
// Stage 2 turns the sampled data into binary codes, a hit flag and sticky bubble-error flags.
module tdc_encoder (
  input  logic        RawdataWrtClk,
  input  logic        ResetFlag,
  input  logic [2:0]  TOACounterA,
  input  logic [2:0]  TOACounterB,
  input  logic [62:0] TOARawData,
  input  logic [2:0]  TOTCounterA,
  input  logic [2:0]  TOTCounterB,
  input  logic [31:0] TOTRawData,
  input  logic [2:0]  CalCounterA,
  input  logic [2:0]  CalCounterB,
  input  logic [62:0] CalRawData,
  input  logic [2:0]  level,
  input  logic        enableMon,
  input  logic [6:0]  offset,
  input  logic        selRawCode,
  input  logic        timeStampMode,
  output logic [9:0]  TOA_codeReg,
  output logic [8:0]  TOT_codeReg,
  output logic [9:0]  Cal_codeReg,
  output logic        hitFlag,
  output logic        TOAerrorFlagReg,
  output logic        TOTerrorFlagReg,
  output logic        CalerrorFlagReg,
  output logic [62:0] TOARawDataMon,
  output logic [31:0] TOTRawDataMon,
  output logic [62:0] CalRawDataMon,
  output logic [2:0]  TOACounterAMon,
  output logic [2:0]  TOACounterBMon,
  output logic [2:0]  TOTCounterAMon,
  output logic [2:0]  TOTCounterBMon,
  output logic [2:0]  CalCounterAMon,
  output logic [2:0]  CalCounterBMon
);

  localparam int unsigned LONG_W     = 63;
  localparam int unsigned TOT_W      = 32;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned FINE_W     = 6;
  localparam int unsigned LONG_CODE_W = 10;
  localparam int unsigned TOT_CODE_W  = 9;

  // Number of set cells in a 63-cell line.
  function automatic logic [FINE_W-1:0] popcnt_long(input logic [LONG_W-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(LONG_W); i++) c = c + FINE_W'(v[i]);
    return c;
  endfunction

  // Number of set cells in the 32-cell TOT line (0..32 fits in 6 bits).
  function automatic logic [FINE_W-1:0] popcnt_tot(input logic [TOT_W-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(TOT_W); i++) c = c + FINE_W'(v[i]);
    return c;
  endfunction

  // Transitions between adjacent cells of a 63-cell line, no wrap-around.
  function automatic logic [FINE_W-1:0] edges_long(input logic [LONG_W-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(LONG_W) - 1; i++) c = c + FINE_W'(v[i] ^ v[i+1]);
    return c;
  endfunction

  // Transitions between adjacent cells of the TOT line, no wrap-around.
  function automatic logic [FINE_W-1:0] edges_tot(input logic [TOT_W-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(TOT_W) - 1; i++) c = c + FINE_W'(v[i] ^ v[i+1]);
    return c;
  endfunction

  // Phase choice for TOA/Cal: fine position plus offset decides which counter is stable.
  function automatic logic [CNT_W-1:0] sel_long(input logic [FINE_W-1:0] f,
                                                input logic [FINE_W-1:0] off,
                                                input logic [CNT_W-1:0]  cnt_a,
                                                input logic [CNT_W-1:0]  cnt_b);
    logic [FINE_W-1:0] s;
    s = f + off;
    return s[FINE_W-1] ? cnt_a : cnt_b;
  endfunction

  // Phase choice for TOT: the TOT cells are twice as long, so the fine code is doubled.
  function automatic logic [CNT_W-1:0] sel_tot(input logic [FINE_W-1:0] f,
                                               input logic [FINE_W-1:0] off,
                                               input logic [CNT_W-1:0]  cnt_a,
                                               input logic [CNT_W-1:0]  cnt_b);
    logic [FINE_W-1:0] s;
    s = FINE_W'({f, 1'b0} + {1'b0, off});
    return s[FINE_W-1] ? cnt_a : cnt_b;
  endfunction

  // Coarse*63 + fine for the 63-cell lines.
  function automatic logic [LONG_CODE_W-1:0] comb_long(input logic [CNT_W-1:0]  c,
                                                       input logic [FINE_W-1:0] f);
    return LONG_CODE_W'({7'd0, c} * 10'd63) + {4'd0, f};
  endfunction

  // Coarse*32 + fine for the TOT line.
  function automatic logic [TOT_CODE_W-1:0] comb_tot(input logic [CNT_W-1:0]  c,
                                                     input logic [FINE_W-1:0] f);
    return {1'b0, c, 5'd0} + {3'd0, f};
  endfunction

  // ---------------- stage 1 state ----------------
  logic [LONG_W-1:0] toa_raw_q, cal_raw_q;
  logic [TOT_W-1:0]  tot_raw_q;
  logic [CNT_W-1:0]  toa_cnt_a_q, toa_cnt_b_q;
  logic [CNT_W-1:0]  tot_cnt_a_q, tot_cnt_b_q;
  logic [CNT_W-1:0]  cal_cnt_a_q, cal_cnt_b_q;

  logic [LONG_W-1:0] toa_mon_q, cal_mon_q;
  logic [TOT_W-1:0]  tot_mon_q;
  logic [CNT_W-1:0]  toa_mon_a_q, toa_mon_b_q;
  logic [CNT_W-1:0]  tot_mon_a_q, tot_mon_b_q;
  logic [CNT_W-1:0]  cal_mon_a_q, cal_mon_b_q;

  // ---------------- stage 2 state ----------------
  logic [LONG_CODE_W-1:0] toa_code_q, cal_code_q;
  logic [TOT_CODE_W-1:0]  tot_code_q;
  logic                   hit_q;
  logic                   toa_err_q, tot_err_q, cal_err_q;

  logic [LONG_CODE_W-1:0] toa_code_d, cal_code_d;
  logic [TOT_CODE_W-1:0]  tot_code_d;
  logic                   hit_d;
  logic                   toa_err_d, tot_err_d, cal_err_d;

  logic [FINE_W-1:0] lvl_c;
  logic [FINE_W-1:0] off_c;
  logic [FINE_W-1:0] toa_f_c, tot_f_c, cal_f_c;
  logic [LONG_CODE_W-1:0] toa_val_c, cal_val_c;

  // offset[6] has no function in the window arithmetic.
  logic unused_offset_msb;
  assign unused_offset_msb = offset[6];

  // Sample raw words and counters for the encoder pipeline.
  always_ff @(posedge RawdataWrtClk or posedge ResetFlag) begin
    if (ResetFlag) begin
      toa_raw_q   <= '0;
      tot_raw_q   <= '0;
      cal_raw_q   <= '0;
      toa_cnt_a_q <= '0;
      toa_cnt_b_q <= '0;
      tot_cnt_a_q <= '0;
      tot_cnt_b_q <= '0;
      cal_cnt_a_q <= '0;
      cal_cnt_b_q <= '0;
    end else begin
      toa_raw_q   <= TOARawData;
      tot_raw_q   <= TOTRawData;
      cal_raw_q   <= CalRawData;
      toa_cnt_a_q <= TOACounterA;
      toa_cnt_b_q <= TOACounterB;
      tot_cnt_a_q <= TOTCounterA;
      tot_cnt_b_q <= TOTCounterB;
      cal_cnt_a_q <= CalCounterA;
      cal_cnt_b_q <= CalCounterB;
    end
  end

  // Monitor copies of the sampled inputs, zeroed when monitoring is disabled.
  always_ff @(posedge RawdataWrtClk or posedge ResetFlag) begin
    if (ResetFlag) begin
      toa_mon_q   <= '0;
      tot_mon_q   <= '0;
      cal_mon_q   <= '0;
      toa_mon_a_q <= '0;
      toa_mon_b_q <= '0;
      tot_mon_a_q <= '0;
      tot_mon_b_q <= '0;
      cal_mon_a_q <= '0;
      cal_mon_b_q <= '0;
    end else if (enableMon) begin
      toa_mon_q   <= TOARawData;
      tot_mon_q   <= TOTRawData;
      cal_mon_q   <= CalRawData;
      toa_mon_a_q <= TOACounterA;
      toa_mon_b_q <= TOACounterB;
      tot_mon_a_q <= TOTCounterA;
      tot_mon_b_q <= TOTCounterB;
      cal_mon_a_q <= CalCounterA;
      cal_mon_b_q <= CalCounterB;
    end else begin
      toa_mon_q   <= '0;
      tot_mon_q   <= '0;
      cal_mon_q   <= '0;
      toa_mon_a_q <= '0;
      toa_mon_b_q <= '0;
      tot_mon_a_q <= '0;
      tot_mon_b_q <= '0;
      cal_mon_a_q <= '0;
      cal_mon_b_q <= '0;
    end
  end

  // Clamp bubble tolerance to 1..3.
  always_comb begin
    lvl_c = FINE_W'(3'd1);
    case (level)
      3'd0:    lvl_c = FINE_W'(3'd1);
      3'd1:    lvl_c = FINE_W'(3'd1);
      3'd2:    lvl_c = FINE_W'(3'd2);
      default: lvl_c = FINE_W'(3'd3);
    endcase
  end

  // Encode stage-1 data into codes, hit and per-sample error indications.
  always_comb begin
    off_c      = offset[5:0];
    toa_f_c    = popcnt_long(toa_raw_q);
    cal_f_c    = popcnt_long(cal_raw_q);
    tot_f_c    = popcnt_tot(tot_raw_q);
    toa_val_c  = {4'd0, toa_f_c};
    cal_val_c  = {4'd0, cal_f_c};
    tot_code_d = {3'd0, tot_f_c};
    if (!selRawCode) begin
      toa_val_c  = comb_long(sel_long(toa_f_c, off_c, toa_cnt_a_q, toa_cnt_b_q), toa_f_c);
      cal_val_c  = comb_long(sel_long(cal_f_c, off_c, cal_cnt_a_q, cal_cnt_b_q), cal_f_c);
      tot_code_d = comb_tot(sel_tot(tot_f_c, off_c, tot_cnt_a_q, tot_cnt_b_q), tot_f_c);
    end
    toa_code_d = toa_val_c;
    cal_code_d = timeStampMode ? cal_val_c : (cal_val_c - toa_val_c);
    hit_d      = |toa_raw_q;
    toa_err_d  = edges_long(toa_raw_q) > lvl_c;
    cal_err_d  = edges_long(cal_raw_q) > lvl_c;
    tot_err_d  = edges_tot(tot_raw_q) > lvl_c;
  end

  // Register codes and hit; error flags accumulate until reset.
  always_ff @(posedge RawdataWrtClk or posedge ResetFlag) begin
    if (ResetFlag) begin
      toa_code_q <= '0;
      tot_code_q <= '0;
      cal_code_q <= '0;
      hit_q      <= 1'b0;
      toa_err_q  <= 1'b0;
      tot_err_q  <= 1'b0;
      cal_err_q  <= 1'b0;
    end else begin
      toa_code_q <= toa_code_d;
      tot_code_q <= tot_code_d;
      cal_code_q <= cal_code_d;
      hit_q      <= hit_d;
      toa_err_q  <= toa_err_q | toa_err_d;
      tot_err_q  <= tot_err_q | tot_err_d;
      cal_err_q  <= cal_err_q | cal_err_d;
    end
  end

  assign TOA_codeReg     = toa_code_q;
  assign TOT_codeReg     = tot_code_q;
  assign Cal_codeReg     = cal_code_q;
  assign hitFlag         = hit_q;
  assign TOAerrorFlagReg = toa_err_q;
  assign TOTerrorFlagReg = tot_err_q;
  assign CalerrorFlagReg = cal_err_q;
  assign TOARawDataMon   = toa_mon_q;
  assign TOTRawDataMon   = tot_mon_q;
  assign CalRawDataMon   = cal_mon_q;
  assign TOACounterAMon  = toa_mon_a_q;
  assign TOACounterBMon  = toa_mon_b_q;
  assign TOTCounterAMon  = tot_mon_a_q;
  assign TOTCounterBMon  = tot_mon_b_q;
  assign CalCounterAMon  = cal_mon_a_q;
  assign CalCounterBMon  = cal_mon_b_q;

endmodule

// File: tb/tb_tdc_encoder.sv
// Directed bench for tdc_encoder: hand-computed codes, flags and monitor values.
module tb_tdc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  toa_a, toa_b, tot_a, tot_b, cal_a, cal_b;
  logic [62:0] toa_raw, cal_raw;
  logic [31:0] tot_raw;
  logic [2:0]  level;
  logic        en_mon, sel_raw, ts_mode;
  logic [6:0]  offset;

  logic [9:0]  toa_code, cal_code;
  logic [8:0]  tot_code;
  logic        hit, toa_err, tot_err, cal_err;
  logic [62:0] toa_mon, cal_mon;
  logic [31:0] tot_mon;
  logic [2:0]  toa_a_mon, toa_b_mon, tot_a_mon, tot_b_mon, cal_a_mon, cal_b_mon;

  int errors = 0;
  int checks = 0;

  tdc_encoder dut (
    .RawdataWrtClk  (clk),
    .ResetFlag      (rst),
    .TOACounterA    (toa_a),
    .TOACounterB    (toa_b),
    .TOARawData     (toa_raw),
    .TOTCounterA    (tot_a),
    .TOTCounterB    (tot_b),
    .TOTRawData     (tot_raw),
    .CalCounterA    (cal_a),
    .CalCounterB    (cal_b),
    .CalRawData     (cal_raw),
    .level          (level),
    .enableMon      (en_mon),
    .offset         (offset),
    .selRawCode     (sel_raw),
    .timeStampMode  (ts_mode),
    .TOA_codeReg    (toa_code),
    .TOT_codeReg    (tot_code),
    .Cal_codeReg    (cal_code),
    .hitFlag        (hit),
    .TOAerrorFlagReg(toa_err),
    .TOTerrorFlagReg(tot_err),
    .CalerrorFlagReg(cal_err),
    .TOARawDataMon  (toa_mon),
    .TOTRawDataMon  (tot_mon),
    .CalRawDataMon  (cal_mon),
    .TOACounterAMon (toa_a_mon),
    .TOACounterBMon (toa_b_mon),
    .TOTCounterAMon (tot_a_mon),
    .TOTCounterBMon (tot_b_mon),
    .CalCounterAMon (cal_a_mon),
    .CalCounterBMon (cal_b_mon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " toa_code"}, 64'(toa_code), 64'd0);
    check({tag, " tot_code"}, 64'(tot_code), 64'd0);
    check({tag, " cal_code"}, 64'(cal_code), 64'd0);
    check({tag, " hit"}, 64'(hit), 64'd0);
    check({tag, " errs"}, 64'({toa_err, tot_err, cal_err}), 64'd0);
    check({tag, " toa_mon"}, 64'(toa_mon), 64'd0);
    check({tag, " tot_mon"}, 64'(tot_mon), 64'd0);
    check({tag, " cnt_mons"}, 64'({toa_a_mon, toa_b_mon, tot_a_mon, tot_b_mon, cal_a_mon, cal_b_mon}), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    toa_a   = 3'd5; toa_b = 3'd2;
    cal_a   = 3'd5; cal_b = 3'd2;
    tot_a   = 3'd1; tot_b = 3'd3;
    toa_raw = 63'((64'd1 << 20) - 64'd1);
    cal_raw = 63'((64'd1 << 20) - 64'd1);
    tot_raw = 32'h0000_FFFF;
    level   = 3'd1;
    en_mon  = 1'b1;
    sel_raw = 1'b0;
    ts_mode = 1'b0;
    offset  = 7'd0;

    // Reset state, including while clocks run
    #2;
    check_all_zero("reset");
    tick(); tick();
    check_all_zero("reset_held");
    rst = 1'b0;

    // First sample: monitors after one edge, codes after two
    tick();
    check("mon_toa_raw", 64'(toa_mon), 64'h0000_0000_000F_FFFF);
    check("mon_tot_raw", 64'(tot_mon), 64'h0000_FFFF);
    check("mon_toa_cnt", 64'({toa_a_mon, toa_b_mon}), 64'({3'd5, 3'd2}));
    check("mon_tot_cnt", 64'({tot_a_mon, tot_b_mon}), 64'({3'd1, 3'd3}));
    check("latency_code", 64'(toa_code), 64'd0);
    check("latency_hit", 64'(hit), 64'd0);
    tick();
    check("toa_b", 64'(toa_code), 64'd146);
    check("hit1", 64'(hit), 64'd1);
    check("tot_a", 64'(tot_code), 64'd48);
    check("cal_minus_toa0", 64'(cal_code), 64'd0);
    check("errs_clean", 64'({toa_err, tot_err, cal_err}), 64'd0);

    // Offset moves TOA into the A window; TOT s=52 stays on A
    offset = 7'd20;
    tick(); tick();
    check("toa_off20", 64'(toa_code), 64'd335);
    check("tot_off20", 64'(tot_code), 64'd48);
    check("cal_off20", 64'(cal_code), 64'd0);

    // offset bit6 is ignored
    offset = 7'd84;
    tick();
    check("toa_off_bit6", 64'(toa_code), 64'd335);

    // Cal fine=10: time-stamp difference wraps
    offset  = 7'd0;
    cal_raw = 63'((64'd1 << 10) - 64'd1);
    tick();
    check("cal_pipe_old", 64'(cal_code), 64'd0);
    tick();
    check("cal_diff_wrap", 64'(cal_code), 64'd1014);
    ts_mode = 1'b1;
    tick();
    check("cal_tsmode1", 64'(cal_code), 64'd136);

    // Fine code only
    sel_raw = 1'b1;
    tick();
    check("toa_raw_code", 64'(toa_code), 64'd20);
    check("tot_raw_code", 64'(tot_code), 64'd16);
    check("cal_raw_code", 64'(cal_code), 64'd10);
    ts_mode = 1'b0;
    tick();
    check("cal_raw_diff", 64'(cal_code), 64'd1014);

    // Full-scale words: TOA 63 ones -> A=7 -> 504; TOT 32 ones, s=0 -> B=3 -> 128
    sel_raw = 1'b0;
    ts_mode = 1'b1;
    toa_a   = 3'd7;
    toa_raw = '1;
    tot_raw = '1;
    tick(); tick();
    check("toa_max", 64'(toa_code), 64'd504);
    check("tot_max", 64'(tot_code), 64'd128);
    check("errs_full", 64'({toa_err, tot_err, cal_err}), 64'd0);

    // Bubble word 1011 (E=3): level 7 clamps to 3 -> no error, code 2*63+3
    toa_raw = 63'b1011;
    level   = 3'd7;
    tick(); tick();
    check("bubble_lvl3_err", 64'(toa_err), 64'd0);
    check("bubble_code", 64'(toa_code), 64'd129);
    // level 0 clamps to 1 -> error
    level = 3'd0;
    tick();
    check("bubble_lvl1_err", 64'(toa_err), 64'd1);
    // Sticky on clean data; other channels unaffected
    toa_raw = 63'((64'd1 << 20) - 64'd1);
    toa_a   = 3'd5;
    tick(); tick(); tick();
    check("bubble_sticky", 64'(toa_err), 64'd1);
    check("sticky_code", 64'(toa_code), 64'd146);
    check("other_errs", 64'({tot_err, cal_err}), 64'd0);

    // Empty TOA word: no hit, s=0 -> B
    toa_raw = '0;
    tick(); tick();
    check("hit0", 64'(hit), 64'd0);
    check("toa_zero_code", 64'(toa_code), 64'd126);

    // Monitors disabled
    en_mon = 1'b0;
    tick();
    check("mon_off_raw", 64'({toa_mon[31:0], cal_mon[31:0]}), 64'd0);
    check("mon_off_tot", 64'(tot_mon), 64'd0);
    check("mon_off_cnt", 64'({toa_a_mon, toa_b_mon, tot_a_mon, tot_b_mon, cal_a_mon, cal_b_mon}), 64'd0);

    // Reset mid-stream, between edges
    en_mon  = 1'b1;
    toa_raw = 63'b1011;
    tick(); tick();
    check("pre_rst_err", 64'(toa_err), 64'd1);
    check("pre_rst_hit", 64'(hit), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
